tpu_tile_sched: RTL

Tile scheduler that sequences the 16x16 systolic TPU through a batch of output tiles. Per tile it streams K packed 128-bit activation and weight words from the activation and weight SRAMs into the TPU, waits for the result, and writes the 16 result rows to the output SRAM. It sits between the host control registers and the TPU core, and owns the TPU's `in_valid` / `mat_DI` / `wei_DI` inputs exclusively.

---
 rtl/tpu_tile_sched.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/tpu_tile_sched.sv
// -----------------------------------------------------------------------------
// tpu_tile_sched
//
// Sequences the 16x16 systolic TPU through a batch of output tiles. For each
// tile it streams K activation/weight word pairs from the A and W SRAMs into
// the TPU, waits for the TPU to produce its 16 result rows, writes those rows
// to the output SRAM, then leaves a short gap so the TPU pipeline drains
// before the next tile is fed.
//
// Ports
//   clk, rst                  : rising-edge clock, synchronous active-high reset
//   start, cfg_*              : batch launch pulse and its configuration
//   a_rd_*, w_rd_*            : SRAM read ports (data returns one cycle later)
//   tpu_in_valid, tpu_*_DI    : TPU input stream (owned exclusively here)
//   tpu_out_valid/done/DO     : TPU result stream
//   o_wr_*                    : output SRAM write port
//   busy, irq, err            : status (irq pulses once per completed batch;
//                               err is sticky until the next accepted start)
// -----------------------------------------------------------------------------
module tpu_tile_sched #(
    parameter int ADDR_W = 12,
    parameter int K_MAX  = 144,
    parameter int TMO    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        cfg_k_len,
    input  logic [7:0]        cfg_tiles,
    input  logic              cfg_w_reuse,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_o_base,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [127:0]      a_rd_data,
    input  logic [127:0]      w_rd_data,
    output logic              tpu_in_valid,
    output logic [127:0]      tpu_mat_DI,
    output logic [127:0]      tpu_wei_DI,
    input  logic              tpu_out_valid,
    input  logic              tpu_done,
    input  logic [127:0]      tpu_DO,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [127:0]      o_wr_data,
    output logic              busy,
    output logic              irq,
    output logic              err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FEED     = 3'd1;
    localparam logic [2:0] S_WAIT_OUT = 3'd2;
    localparam logic [2:0] S_COLLECT  = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_COMPLETE = 3'd5;
    localparam logic [2:0] S_ERROR    = 3'd6;

    localparam logic [7:0]        K_MAX_W  = 8'(K_MAX);
    localparam logic [8:0]        TMO_M1   = 9'(TMO - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [2:0]        state;
    logic [7:0]        k_len_q;
    logic [7:0]        tiles_q;
    logic              reuse_q;
    logic [ADDR_W-1:0] w_base_q;
    logic [7:0]        k_cnt;
    logic [7:0]        tile_cnt;
    logic [3:0]        row_cnt;
    logic [8:0]        wd_cnt;
    logic              gap_cnt;
    logic [ADDR_W-1:0] o_ptr;

    logic       cfg_bad;
    logic [8:0] wd_last;
    logic       last_row;

    assign cfg_bad  = (cfg_k_len == 8'd0) || (cfg_k_len > K_MAX_W) || (cfg_tiles == 8'd0);
    assign wd_last  = {1'b0, k_len_q} + TMO_M1;
    assign last_row = (row_cnt == 4'd15);

    // The SRAM data only exists in the cycle after the read, which is the very
    // cycle tpu_in_valid (a registered copy of the read enable) is high. The
    // data is therefore gated by that valid instead of taking another register
    // stage, which keeps the TPU bus at zero outside the K feed cycles.
    assign tpu_mat_DI = tpu_in_valid ? a_rd_data : '0;
    assign tpu_wei_DI = tpu_in_valid ? w_rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            k_len_q      <= '0;
            tiles_q      <= '0;
            reuse_q      <= 1'b0;
            w_base_q     <= '0;
            k_cnt        <= '0;
            tile_cnt     <= '0;
            row_cnt      <= '0;
            wd_cnt       <= '0;
            gap_cnt      <= 1'b0;
            o_ptr        <= '0;
            a_rd_en      <= 1'b0;
            a_rd_addr    <= '0;
            w_rd_en      <= 1'b0;
            w_rd_addr    <= '0;
            tpu_in_valid <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            busy         <= 1'b0;
            irq          <= 1'b0;
            err          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // pre-edge values, regardless of statement order in this block.
            tpu_in_valid <= a_rd_en;
            o_wr_en      <= 1'b0;
            irq          <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        err  <= cfg_bad;
                        if (cfg_bad) begin
                            state <= S_ERROR;
                        end else begin
                            k_len_q   <= cfg_k_len;
                            tiles_q   <= cfg_tiles;
                            reuse_q   <= cfg_w_reuse;
                            w_base_q  <= cfg_w_base;
                            k_cnt     <= '0;
                            tile_cnt  <= '0;
                            row_cnt   <= '0;
                            o_ptr     <= cfg_o_base;
                            a_rd_en   <= 1'b1;
                            w_rd_en   <= 1'b1;
                            a_rd_addr <= cfg_a_base;
                            w_rd_addr <= cfg_w_base;
                            state     <= S_FEED;
                        end
                    end
                end

                // Reads are issued while a_rd_en is high; the cycle after the
                // last read is spent letting the final word reach the TPU.
                // Address registers run on linearly across tiles, so the
                // t*K + k offset never needs a multiplier.
                S_FEED: begin
                    if (a_rd_en) begin
                        a_rd_addr <= a_rd_addr + ADDR_ONE;
                        if (k_cnt == k_len_q - 8'd1) begin
                            a_rd_en   <= 1'b0;
                            w_rd_en   <= 1'b0;
                            w_rd_addr <= reuse_q ? w_base_q : w_rd_addr + ADDR_ONE;
                        end else begin
                            k_cnt     <= k_cnt + 8'd1;
                            w_rd_addr <= w_rd_addr + ADDR_ONE;
                        end
                    end else begin
                        wd_cnt <= '0;
                        state  <= S_WAIT_OUT;
                    end
                end

                // Row 0 arrives on the edge that leaves WAIT_OUT, so both
                // states share the write/row-check path.
                S_WAIT_OUT, S_COLLECT: begin
                    if (tpu_out_valid) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= o_ptr;
                        o_wr_data <= tpu_DO;
                        o_ptr     <= o_ptr + ADDR_ONE;
                        row_cnt   <= row_cnt + 4'd1;
                        if (tpu_done != last_row) begin
                            err   <= 1'b1;
                            state <= S_ERROR;
                        end else if (last_row) begin
                            gap_cnt <= 1'b0;
                            state   <= S_GAP;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end else if (state == S_WAIT_OUT) begin
                        if (wd_cnt == wd_last) begin
                            err   <= 1'b1;
                            state <= S_ERROR;
                        end else begin
                            wd_cnt <= wd_cnt + 9'd1;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt) begin
                        if (tile_cnt == tiles_q - 8'd1) begin
                            irq   <= 1'b1;
                            state <= S_COMPLETE;
                        end else begin
                            tile_cnt <= tile_cnt + 8'd1;
                            k_cnt    <= '0;
                            a_rd_en  <= 1'b1;
                            w_rd_en  <= 1'b1;
                            state    <= S_FEED;
                        end
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end

                S_COMPLETE, S_ERROR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
